// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared register-file definitions for the write-port arbiter and its scoreboard.
package cpu_defs;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WBU  = 2'd1,
    GNT_MCU  = 2'd2
  } grant_e;

endpackage

// File: rtl/regfile_wport_arbiter_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, operand hazard lookup
// and a sticky protocol-violation flag.
module regfile_scoreboard
  import cpu_defs::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  reg_addr_t           set_addr,
  input  logic                clr_en,
  input  reg_addr_t           clr_addr,
  input  logic                wb_acc,
  input  reg_addr_t           wb_addr,
  input  reg_addr_t           rd_a_addr,
  input  reg_addr_t           rd_b_addr,
  output logic                hazard_a,
  output logic                hazard_b,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                sb_err
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                sb_err_q;
  logic                sb_err_d;
  logic                set_nz;
  logic                same_reg_clr;

  assign set_nz       = set_en && (set_addr != ZERO_REG);
  assign same_reg_clr = clr_en && (clr_addr == set_addr);

  // Set is applied after clear so a back-to-back issue keeps the bit busy.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_d[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;
        assign set_hit    = set_nz && (set_addr == reg_addr_t'(gi));
        assign clr_hit    = clr_en && (clr_addr == reg_addr_t'(gi));
        assign busy_d[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_q[gi]);
      end
    end
  endgenerate

  always_comb begin
    sb_err_d = sb_err_q;
    if (set_nz && busy_q[set_addr] && !same_reg_clr)
      sb_err_d = 1'b1;
    if (clr_en && (clr_addr != ZERO_REG) && !busy_q[clr_addr])
      sb_err_d = 1'b1;
    if (wb_acc && busy_q[wb_addr])
      sb_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign hazard_a = !rst && busy_q[rd_a_addr];
  assign hazard_b = !rst && busy_q[rd_b_addr];
  assign busy_vec = busy_q;
  assign sb_err   = sb_err_q;

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Single register-file write port shared by WBU and MCU, with a starvation
// counter that eventually gives the MCU priority.
module regfile_wport_arbiter
  import cpu_defs::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  wb_stall,
  input  logic                  mc_issue,
  input  logic [REG_ADDR_W-1:0] mc_issue_addr,
  input  logic                  mc_valid,
  input  logic [REG_ADDR_W-1:0] mc_addr,
  input  logic [DATA_W-1:0]     mc_data,
  output logic                  mc_ready,
  input  logic [REG_ADDR_W-1:0] rd_a_addr,
  input  logic [REG_ADDR_W-1:0] rd_b_addr,
  output logic                  hazard_a,
  output logic                  hazard_b,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  sb_err
);

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;
  logic             mc_prio_q;
  logic             mc_prio_d;
  logic             wb_acc;
  grant_e           gnt;

  assign mc_ready = !rst && mc_valid && (mc_prio_q || !wb_we);
  assign wb_stall = !rst && mc_prio_q && wb_we && mc_valid;
  assign wb_acc   = !rst && wb_we && !wb_stall;

  // The two accept terms are mutually exclusive, so MCU-first ordering is only
  // a tie-break for readability.
  always_comb begin
    gnt = GNT_NONE;
    if (mc_ready)
      gnt = GNT_MCU;
    else if (wb_acc)
      gnt = GNT_WBU;
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ZERO_REG;
    rf_wdata = '0;
    case (gnt)
      GNT_MCU: begin
        rf_waddr = mc_addr;
        rf_wdata = mc_data;
        rf_we    = (mc_addr != ZERO_REG);
      end
      GNT_WBU: begin
        rf_waddr = wb_addr;
        rf_wdata = wb_data;
        rf_we    = (wb_addr != ZERO_REG);
      end
      default: ;
    endcase
  end

  // Priority is raised together with the count reaching its limit so the MCU
  // wins on the very next cycle.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    mc_prio_d  = mc_prio_q;
    if (mc_ready) begin
      wait_cnt_d = '0;
      mc_prio_d  = 1'b0;
    end else if (mc_valid) begin
      if (wait_cnt_q < WAIT_MAX)
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      if (wait_cnt_d == WAIT_MAX)
        mc_prio_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      mc_prio_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      mc_prio_q  <= mc_prio_d;
    end
  end

  regfile_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (mc_issue),
    .set_addr  (mc_issue_addr),
    .clr_en    (mc_ready),
    .clr_addr  (mc_addr),
    .wb_acc    (wb_acc),
    .wb_addr   (wb_addr),
    .rd_a_addr (rd_a_addr),
    .rd_b_addr (rd_b_addr),
    .hazard_a  (hazard_a),
    .hazard_b  (hazard_b),
    .busy_vec  (busy_vec),
    .sb_err    (sb_err)
  );

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed vector bench for regfile_wport_arbiter plus a starvation sequence.
module tb_regfile_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        mc_issue;
  logic [4:0]  mc_issue_addr;
  logic        mc_valid;
  logic [4:0]  mc_addr;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic [4:0]  rd_a_addr;
  logic [4:0]  rd_b_addr;
  logic        hazard_a;
  logic        hazard_b;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_vec;
  logic        sb_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wport_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .mc_issue(mc_issue), .mc_issue_addr(mc_issue_addr),
    .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data), .mc_ready(mc_ready),
    .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .hazard_a(hazard_a), .hazard_b(hazard_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_vec(busy_vec), .sb_err(sb_err)
  );

  typedef struct {
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        iss;
    logic [4:0]  iss_addr;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        e_stall;
    logic        e_ready;
    logic        e_ha;
    logic        e_hb;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [31:0] e_busy;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic r, logic we, logic [4:0] wa, logic [31:0] wd,
    logic is, logic [4:0] ia, logic mv, logic [4:0] ma, logic [31:0] md,
    logic [4:0] ra, logic [4:0] rb,
    logic es, logic er, logic eha, logic ehb, logic ewe,
    logic [4:0] ewa, logic [31:0] ewd, logic [31:0] eb, logic ee);
    vec_t v;
    v.rst = r;  v.wb_we = we; v.wb_addr = wa; v.wb_data = wd;
    v.iss = is; v.iss_addr = ia; v.mv = mv; v.ma = ma; v.md = md;
    v.ra = ra;  v.rb = rb;
    v.e_stall = es; v.e_ready = er; v.e_ha = eha; v.e_hb = ehb; v.e_we = ewe;
    v.e_waddr = ewa; v.e_wdata = ewd; v.e_busy = eb; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=0x%08h expected=0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; wb_we = v.wb_we; wb_addr = v.wb_addr; wb_data = v.wb_data;
    mc_issue = v.iss; mc_issue_addr = v.iss_addr;
    mc_valid = v.mv; mc_addr = v.ma; mc_data = v.md;
    rd_a_addr = v.ra; rd_b_addr = v.rb;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    chk("wb_stall", idx, 32'(wb_stall), 32'(v.e_stall));
    chk("mc_ready", idx, 32'(mc_ready), 32'(v.e_ready));
    chk("hazard_a", idx, 32'(hazard_a), 32'(v.e_ha));
    chk("hazard_b", idx, 32'(hazard_b), 32'(v.e_hb));
    chk("rf_we",    idx, 32'(rf_we),    32'(v.e_we));
    chk("rf_waddr", idx, 32'(rf_waddr), 32'(v.e_waddr));
    chk("rf_wdata", idx, rf_wdata,      v.e_wdata);
    chk("busy_vec", idx, busy_vec,      v.e_busy);
    chk("sb_err",   idx, 32'(sb_err),   32'(v.e_err));
    $display("vec %0d: rst=%0b wb=%0b/%0d mc=%0b/%0d iss=%0b/%0d -> stall=%0b rdy=%0b we=%0b waddr=%0d busy=%08h err=%0b",
             idx, v.rst, v.wb_we, v.wb_addr, v.mv, v.ma, v.iss, v.iss_addr,
             wb_stall, mc_ready, rf_we, rf_waddr, busy_vec, sb_err);
  endtask

  initial begin
    int refused;
    vec_t idle;
    rst = 1'b1; wb_we = 0; wb_addr = 0; wb_data = 0; mc_issue = 0; mc_issue_addr = 0;
    mc_valid = 0; mc_addr = 0; mc_data = 0; rd_a_addr = 0; rd_b_addr = 0;
    repeat (2) @(posedge clk);

    //             rst we wa  wdata         is ia  mv ma  mdata        ra rb | st rd ha hb we wa  wdata         busy         err
    // reset holds all combinational outputs low even with requests present
    vecs.push_back(mk(1, 1, 3,  32'h11,       1, 9,  1, 6,  32'h66,      9, 6,  0, 0, 0, 0, 0, 0,  32'h0,        32'h0,       0));
    // WBU write goes straight through; issue r6 for the next test
    vecs.push_back(mk(0, 1, 3,  32'h12345678, 1, 6,  0, 0,  32'h0,       0, 0,  0, 0, 0, 0, 1, 3,  32'h12345678, 32'h0,       0));
    // contention without priority: WBU wins
    vecs.push_back(mk(0, 1, 5,  32'h55,       0, 0,  1, 6,  32'h66,      0, 6,  0, 0, 0, 1, 1, 5,  32'h55,       32'h40,      0));
    // WBU idle: MCU accepted, hazard still visible on accept cycle
    vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  1, 6,  32'h66,      0, 6,  0, 1, 0, 1, 1, 6,  32'h66,       32'h40,      0));
    // bit cleared after accept; issue r10 for starvation test
    vecs.push_back(mk(0, 0, 0,  32'h0,        1, 10, 0, 0,  32'h0,       0, 6,  0, 0, 0, 0, 0, 0,  32'h0,        32'h0,       0));
    // four refusals while WBU writes every cycle
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 1, 1, 32'(i),     0, 0,  1, 10, 32'hAA,      0, 0,  0, 0, 0, 0, 1, 1,  32'(i),       32'h400,     0));
    // fifth cycle: priority, WBU stalled, MCU writes
    vecs.push_back(mk(0, 1, 1,  32'h9,        0, 0,  1, 10, 32'hAA,      0, 0,  1, 1, 0, 0, 1, 10, 32'hAA,       32'h400,     0));
    // priority dropped: WBU wins again
    vecs.push_back(mk(0, 1, 1,  32'h77,       0, 0,  1, 10, 32'hAA,      0, 0,  0, 0, 0, 0, 1, 1,  32'h77,       32'h0,       0));
    // idle: no grant drives zeros
    vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,       0, 0,  0, 0, 0, 0, 0, 0,  32'h0,        32'h0,       0));
    // hazard on r9 appears the cycle after issue
    vecs.push_back(mk(0, 0, 0,  32'h0,        1, 9,  0, 0,  32'h0,       9, 0,  0, 0, 0, 0, 0, 0,  32'h0,        32'h0,       0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,       9, 0,  0, 0, 1, 0, 0, 0,  32'h0,        32'h200,     0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  1, 9,  32'h99,      9, 0,  0, 1, 1, 0, 1, 9,  32'h99,       32'h200,     0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,       9, 0,  0, 0, 0, 0, 0, 0,  32'h0,        32'h0,       0));
    // r0: issue ignored, MCU and WBU handshakes complete with no write
    vecs.push_back(mk(0, 0, 0,  32'h0,        1, 0,  0, 0,  32'h0,       0, 0,  0, 0, 0, 0, 0, 0,  32'h0,        32'h0,       0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  1, 0,  32'hDEAD,    0, 0,  0, 1, 0, 0, 0, 0,  32'hDEAD,     32'h0,       0));
    vecs.push_back(mk(0, 1, 0,  32'hBEEF,     0, 0,  0, 0,  32'h0,       0, 0,  0, 0, 0, 0, 0, 0,  32'hBEEF,     32'h0,       0));
    // double issue of r7 sets the sticky error
    vecs.push_back(mk(0, 0, 0,  32'h0,        1, 7,  0, 0,  32'h0,       0, 0,  0, 0, 0, 0, 0, 0,  32'h0,        32'h0,       0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        1, 7,  0, 0,  32'h0,       0, 0,  0, 0, 0, 0, 0, 0,  32'h0,        32'h80,      0));
    vecs.push_back(mk(0, 1, 2,  32'h1,        0, 0,  0, 0,  32'h0,       7, 0,  0, 0, 1, 0, 1, 2,  32'h1,        32'h80,      1));
    // mid-stream reset: outputs gated, state clears on the edge
    vecs.push_back(mk(1, 1, 3,  32'h3,        0, 0,  0, 0,  32'h0,       7, 0,  0, 0, 0, 0, 0, 0,  32'h0,        32'h80,      1));
    vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,       7, 0,  0, 0, 0, 0, 0, 0,  32'h0,        32'h0,       0));
    // re-issue of r12 on its accept cycle: set wins, no error
    vecs.push_back(mk(0, 0, 0,  32'h0,        1, 12, 0, 0,  32'h0,       0, 0,  0, 0, 0, 0, 0, 0,  32'h0,        32'h0,       0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        1, 12, 1, 12, 32'h5,       0, 0,  0, 1, 0, 0, 1, 12, 32'h5,        32'h1000,    0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,       0, 0,  0, 0, 0, 0, 0, 0,  32'h0,        32'h1000,    0));
    // WBU write to a pending register flags WAW but still writes
    vecs.push_back(mk(0, 1, 12, 32'hC,        0, 0,  0, 0,  32'h0,       0, 0,  0, 0, 0, 0, 1, 12, 32'hC,        32'h1000,    0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,       0, 0,  0, 0, 0, 0, 0, 0,  32'h0,        32'h1000,    1));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    // Starvation sequence after a fresh reset: count refusals, bounded.
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(idle);
    @(negedge clk); rst = 0; mc_issue = 1; mc_issue_addr = 15;
    @(negedge clk); mc_issue = 0;
    wb_we = 1; wb_addr = 1; wb_data = 32'h1; mc_valid = 1; mc_addr = 15; mc_data = 32'hF0F0;
    refused = 0;
    #1;
    while (!mc_ready && refused < 20) begin
      refused++;
      @(negedge clk);
      #1;
    end
    chk("starve_refusals", 100, 32'(refused), 32'd4);
    chk("starve_stall",    100, 32'(wb_stall), 32'd1);
    chk("starve_waddr",    100, 32'(rf_waddr), 32'd15);
    chk("starve_wdata",    100, rf_wdata,      32'hF0F0);
    $display("starve: refused=%0d stall=%0b waddr=%0d", refused, wb_stall, rf_waddr);
    @(negedge clk); #1;
    chk("prio_cleared_ready", 101, 32'(mc_ready), 32'd0);
    chk("prio_cleared_stall", 101, 32'(wb_stall), 32'd0);
    chk("prio_cleared_busy",  101, busy_vec,      32'h0);
    $display("post-grant: ready=%0b stall=%0b busy=%08h", mc_ready, wb_stall, busy_vec);
    @(negedge clk);
    wb_we = 0; mc_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
